// File: rtl/ex_div_pkg.sv
// Shared definitions for the execute-stage divider: op codes, FSM states, iteration count.
// Configuration macro consumed by ex_div: DIV_FAST_SPECIAL_EN.
package ex_div_pkg;

    localparam int unsigned RegBus = 32;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    localparam int unsigned DIV_ITER = 32;

    typedef enum logic [1:0] {
        DIV_ST_IDLE = 2'b00,
        DIV_ST_CALC = 2'b01,
        DIV_ST_DONE = 2'b10
    } div_state_e;

    // DIV and REM are the signed flavours (op bit 0 clear).
    function automatic logic div_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic div_sel_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider (RV32M DIV/DIVU/REM/REMU) with pipeline stall request.
// Define DIV_FAST_SPECIAL_EN to finish divide-by-zero and signed overflow in a single cycle.
module ex_div
    import ex_div_pkg::*;
#(
    parameter int unsigned XLEN = RegBus
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic [4:0]      rd_wa_i,
    output logic            busy_o,
    output logic            stall_req_o,
    output logic            ready_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_wa_o
);

    localparam logic [5:0] LastCnt = 6'(DIV_ITER - 1);

    div_state_e      state_q, state_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic            spec_q, spec_d;
    logic [XLEN-1:0] spec_val_q, spec_val_d;
    logic            ready_q, ready_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      rd_out_q, rd_out_d;

    // Operand decode at accept time
    logic            in_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_abs, b_abs;
    logic            in_div_zero, in_ovf, in_special;
    logic [XLEN-1:0] in_spec_val;
    logic            accept;

    always_comb begin
        in_signed   = div_is_signed(op_i);
        a_neg       = in_signed & dividend_i[XLEN-1];
        b_neg       = in_signed & divisor_i[XLEN-1];
        a_abs       = a_neg ? -dividend_i : dividend_i;
        b_abs       = b_neg ? -divisor_i : divisor_i;
        in_div_zero = (divisor_i == '0);
        in_ovf      = in_signed & (dividend_i == {1'b1, {(XLEN-1){1'b0}}})
                      & (divisor_i == '1);
        in_special  = in_div_zero | in_ovf;
        if (in_div_zero) begin
            in_spec_val = div_sel_rem(op_i) ? dividend_i : '1;
        end else begin
            in_spec_val = div_sel_rem(op_i) ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
        accept = (state_q == DIV_ST_IDLE) & start_i & ~flush_i;
    end

    // One restoring step: the dividend shifts out of quo_q's MSB as quotient bits enter its LSB.
    logic [XLEN:0]   rem_shift, rem_diff, step_rem;
    logic            q_bit;
    logic [XLEN-1:0] step_quo, fin_quo, fin_rem, fin_val;

    always_comb begin
        rem_shift = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
        rem_diff  = rem_shift - {1'b0, dvs_q};
        q_bit     = ~rem_diff[XLEN];
        step_rem  = q_bit ? rem_diff : rem_shift;
        step_quo  = {quo_q[XLEN-2:0], q_bit};
        fin_quo   = q_neg_q ? -step_quo : step_quo;
        fin_rem   = r_neg_q ? -step_rem[XLEN-1:0] : step_rem[XLEN-1:0];
        if (spec_q) begin
            fin_val = spec_val_q;
        end else begin
            fin_val = div_sel_rem(op_q) ? fin_rem : fin_quo;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        rd_d       = rd_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        rem_d      = rem_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        spec_d     = spec_q;
        spec_val_d = spec_val_q;
        ready_d    = 1'b0;
        result_d   = result_q;
        rd_out_d   = rd_out_q;

        unique case (state_q)
            DIV_ST_IDLE: begin
                if (accept) begin
                    op_d       = op_i;
                    rd_d       = rd_wa_i;
                    quo_d      = a_abs;
                    dvs_d      = b_abs;
                    rem_d      = '0;
                    cnt_d      = '0;
                    q_neg_d    = a_neg ^ b_neg;
                    r_neg_d    = a_neg;
                    spec_d     = in_special;
                    spec_val_d = in_spec_val;
`ifdef DIV_FAST_SPECIAL_EN
                    if (in_special) begin
                        state_d  = DIV_ST_DONE;
                        ready_d  = 1'b1;
                        result_d = in_spec_val;
                        rd_out_d = rd_wa_i;
                    end else begin
                        state_d = DIV_ST_CALC;
                    end
`else
                    state_d = DIV_ST_CALC;
`endif
                end
            end
            DIV_ST_CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LastCnt) begin
                    state_d  = DIV_ST_DONE;
                    ready_d  = 1'b1;
                    result_d = fin_val;
                    rd_out_d = rd_q;
                end
            end
            DIV_ST_DONE: begin
                state_d = DIV_ST_IDLE;
            end
            default: begin
                state_d = DIV_ST_IDLE;
            end
        endcase

        // A flush on the final iteration must not publish a result.
        if (flush_i) begin
            state_d  = DIV_ST_IDLE;
            ready_d  = 1'b0;
            result_d = result_q;
            rd_out_d = rd_out_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= DIV_ST_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            rd_q       <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            spec_q     <= 1'b0;
            spec_val_q <= '0;
            ready_q    <= 1'b0;
            result_q   <= '0;
            rd_out_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            rem_q      <= rem_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            spec_q     <= spec_d;
            spec_val_q <= spec_val_d;
            ready_q    <= ready_d;
            result_q   <= result_d;
            rd_out_q   <= rd_out_d;
        end
    end

    assign busy_o      = (state_q != DIV_ST_IDLE);
    assign stall_req_o = accept | (state_q == DIV_ST_CALC);
    assign ready_o     = ready_q;
    assign result_o    = result_q;
    assign rd_wa_o     = rd_out_q;

endmodule
